key_sweep_ctrl: RTL and testbench

Sequencer that drives a key-locked c499-class combinational netlist and narrows its key space against an oracle. It accepts golden (input pattern, response) pairs over a valid/ready stream and applies each pattern under every still-surviving key. It waits a fixed settle time, compares the netlist outputs with the golden response, and removes mismatching keys from a survivor mask. It sits between the pattern/oracle source and the locked datapath's key pins (D_0 = KEY[0], D_1 = KEY[1]).

---
 rtl/key_sweep_ctrl.sv | 109 ++++++++++
 tb/tb_key_sweep_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_sweep_ctrl.sv
// key_sweep_ctrl: narrows a locked netlist's key space by replaying oracle pattern pairs under every surviving key
module key_sweep_ctrl #(
  parameter int KEY_W  = 2,
  parameter int DIN_W  = 41,
  parameter int DOUT_W = 32,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  PAT_VALID,
  output logic                  PAT_READY,
  input  logic [DIN_W-1:0]      PAT_DATA,
  input  logic [DOUT_W-1:0]     PAT_RESP,
  input  logic                  PAT_LAST,
  output logic [DIN_W-1:0]      LOCK_IN,
  output logic [KEY_W-1:0]      KEY,
  input  logic [DOUT_W-1:0]     LOCK_OUT,
  output logic [(1<<KEY_W)-1:0] ALIVE_MASK,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FOUND,
  output logic [KEY_W-1:0]      KEY_OUT,
  output logic [CNT_W-1:0]      PAT_CNT
);
  localparam int NK = 1 << KEY_W;
  localparam int NW = KEY_W + 1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_APPLY, S_SETTLE, S_CHECK, S_NEXT, S_DONE} state_t;
  state_t              state;
  logic [DOUT_W-1:0]   resp;
  logic                last;
  logic [KEY_W-1:0]    idx;
  logic [3:0]          cnt;
  logic [NW-1:0]       n;
  logic [KEY_W-1:0]    low;
  // Survivor count and lowest survivor; the mask is already updated by CHECK when NEXT reads these
  always_comb begin
    n   = '0;
    low = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      n = n + NW'(ALIVE_MASK[i]);
      if (ALIVE_MASK[i]) low = KEY_W'(i);
    end
  end
  assign PAT_READY = (state == S_WAIT);
  assign BUSY      = (state != S_IDLE) && (state != S_DONE);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      ALIVE_MASK <= '1;
      PAT_CNT    <= '0;
      LOCK_IN    <= '0;
      KEY        <= '0;
      DONE       <= 1'b0;
      FOUND      <= 1'b0;
      KEY_OUT    <= '0;
      resp       <= '0;
      last       <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (START) begin
          ALIVE_MASK <= '1;
          PAT_CNT    <= '0;
          DONE       <= 1'b0;
          FOUND      <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: if (PAT_VALID) begin
          LOCK_IN <= PAT_DATA;
          resp    <= PAT_RESP;
          last    <= PAT_LAST;
          idx     <= '0;
          state   <= S_APPLY;
        end
        S_APPLY: if (ALIVE_MASK[idx]) begin
          KEY   <= idx;
          cnt   <= 4'(SETTLE);
          state <= S_SETTLE;
        end else begin
          state <= S_NEXT;
        end
        S_SETTLE: if (cnt == 4'd1) state <= S_CHECK;
                  else cnt <= cnt - 4'd1;
        S_CHECK: begin
          if (LOCK_OUT != resp) ALIVE_MASK[idx] <= 1'b0;
          state <= S_NEXT;
        end
        S_NEXT: if (idx == KEY_W'(NK - 1)) begin
          if (PAT_CNT != '1) PAT_CNT <= PAT_CNT + 1'b1;
          if (last || n <= NW'(1)) begin
            DONE    <= 1'b1;
            FOUND   <= (n == NW'(1));
            KEY_OUT <= low;
            state   <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end else begin
          idx   <= idx + 1'b1;
          state <= S_APPLY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_sweep_ctrl.sv
// tb_key_sweep_ctrl: directed checks of key_sweep_ctrl against a behavioural locked netlist whose correct key is 2'b11
module tb_key_sweep_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1, START = 1'b0, PAT_VALID = 1'b0, PAT_LAST = 1'b0;
  logic        PAT_READY, BUSY, DONE, FOUND;
  logic [40:0] PAT_DATA = '0, LOCK_IN;
  logic [31:0] PAT_RESP = '0, LOCK_OUT;
  logic [1:0]  KEY, KEY_OUT;
  logic [3:0]  ALIVE_MASK;
  logic [15:0] PAT_CNT;
  int cyc = 0, evals = 0, fails = 0;

  key_sweep_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .PAT_VALID(PAT_VALID), .PAT_READY(PAT_READY),
    .PAT_DATA(PAT_DATA), .PAT_RESP(PAT_RESP), .PAT_LAST(PAT_LAST), .LOCK_IN(LOCK_IN),
    .KEY(KEY), .LOCK_OUT(LOCK_OUT), .ALIVE_MASK(ALIVE_MASK), .BUSY(BUSY), .DONE(DONE),
    .FOUND(FOUND), .KEY_OUT(KEY_OUT), .PAT_CNT(PAT_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] golden(input logic [40:0] x);
    return x[31:0] ^ {23'd0, x[40:32]};
  endfunction
  function automatic logic [40:0] mk(input logic [37:0] hi, input logic [2:0] lo);
    return {hi, lo};
  endfunction
  // Wrong key k corrupts the output whenever input bit k is set; key 3 is always correct
  always_comb LOCK_OUT = golden(LOCK_IN) ^ ((KEY != 2'd3 && LOCK_IN[KEY]) ? 32'hDEAD0000 : 32'h0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic send(input logic [40:0] d, input logic [31:0] r, input logic l, output int at);
    int w = 0;
    @(negedge CLK);
    PAT_DATA = d; PAT_RESP = r; PAT_LAST = l; PAT_VALID = 1'b1;
    while (!PAT_READY && w < 300) begin @(negedge CLK); w++; end
    at = cyc;
    check("accept_in_time", 64'(w < 300), 64'd1);
    @(negedge CLK); PAT_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (!DONE && w < 300) begin @(negedge CLK); w++; end
    check("done_in_time", 64'(DONE), 64'd1);
  endtask

  initial begin
    int a1, a2, a3, a4, rdy;
    logic [40:0] p;
    repeat (2) @(negedge CLK);
    check("rst_alive", 64'(ALIVE_MASK), 64'hF);
    check("rst_cnt", 64'(PAT_CNT), 64'd0);
    check("rst_lockin", 64'(LOCK_IN), 64'd0);
    check("rst_flags", 64'({PAT_READY, BUSY, DONE, FOUND, KEY, KEY_OUT}), 64'd0);
    RST = 1'b0;

    // Full sweep: four patterns, idle gap in WAIT_PAT, mid-sweep START, latency with 2 live keys
    pulse_start();
    check("start_busy", 64'({BUSY, PAT_READY, DONE}), 64'b110);
    p = mk(38'h2A5F3C1B7, 3'b000);
    send(p, golden(p), 1'b0, a1);
    repeat (25) @(negedge CLK);
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (PAT_READY && BUSY) rdy++;
    end
    check("idle_wait_ready_busy", 64'(rdy), 64'd10);
    check("idle_wait_mask", 64'({ALIVE_MASK, PAT_CNT}), {44'd0, 4'hF, 16'd1});
    p = mk(38'h013579BDF, 3'b011);
    send(p, golden(p), 1'b0, a2);
    p = mk(38'h3C0FFEE11, 3'b000);
    send(p, golden(p), 1'b0, a3);
    pulse_start();
    check("start_ignored_busy", 64'(BUSY), 64'd1);
    p = mk(38'h1BADC0DE5, 3'b100);
    send(p, golden(p), 1'b1, a4);
    check("latency_2live_2dead", 64'(a4 - a3), 64'd15);
    wait_done();
    check("sweep_found", 64'(FOUND), 64'd1);
    check("sweep_key", 64'(KEY_OUT), 64'd3);
    check("sweep_mask", 64'(ALIVE_MASK), 64'b1000);
    check("sweep_cnt", 64'(PAT_CNT), 64'd4);
    check("sweep_busy", 64'(BUSY), 64'd0);

    // Early exit: first pattern kills keys 0..2, next pair must never be accepted
    pulse_start();
    check("restart_clears", 64'({DONE, FOUND, ALIVE_MASK, PAT_CNT}), {42'd0, 2'b00, 4'hF, 16'd0});
    p = mk(38'h0F0F0F0F0, 3'b111);
    send(p, golden(p), 1'b0, a1);
    p = mk(38'h155555555, 3'b010);
    PAT_DATA = p; PAT_RESP = golden(p); PAT_LAST = 1'b0; PAT_VALID = 1'b1;
    rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (PAT_READY) rdy++;
    end
    check("early_no_ready", 64'(rdy), 64'd0);
    wait_done();
    PAT_VALID = 1'b0;
    check("early_result", 64'({FOUND, KEY_OUT, ALIVE_MASK, PAT_CNT}), {41'd0, 1'b1, 2'd3, 4'b1000, 16'd1});

    // Ambiguity: keys 1 and 3 both survive the only pattern
    pulse_start();
    p = mk(38'h2468ACE02, 3'b101);
    send(p, golden(p), 1'b1, a1);
    wait_done();
    check("amb_found", 64'(FOUND), 64'd0);
    check("amb_mask", 64'(ALIVE_MASK), 64'b1010);
    check("amb_key", 64'(KEY_OUT), 64'd1);

    // Reset during SETTLE of key 1
    pulse_start();
    p = mk(38'h3FFFFFFFF, 3'b000);
    send(p, golden(p), 1'b0, a1);
    repeat (6) @(negedge CLK);
    check("pre_rst_key", 64'(KEY), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_mask_cnt", 64'({ALIVE_MASK, PAT_CNT}), {44'd0, 4'hF, 16'd0});
    check("midrst_key_lockin", 64'({KEY, LOCK_IN}), 64'd0);
    check("midrst_flags", 64'({BUSY, DONE, FOUND, PAT_READY}), 64'd0);
    pulse_start();
    p = mk(38'h123456789, 3'b111);
    send(p, golden(p), 1'b1, a1);
    wait_done();
    check("post_rst_result", 64'({FOUND, KEY_OUT, ALIVE_MASK, PAT_CNT}), {41'd0, 1'b1, 2'd3, 4'b1000, 16'd1});

    // Corrupted oracle response: no key is consistent
    pulse_start();
    p = mk(38'h0DEADBEEF, 3'b000);
    send(p, golden(p) ^ 32'h1, 1'b1, a1);
    wait_done();
    check("bad_oracle", 64'({FOUND, KEY_OUT, ALIVE_MASK, PAT_CNT}), {41'd0, 1'b0, 2'd0, 4'b0000, 16'd1});
    repeat (3) @(negedge CLK);
    check("done_held", 64'({DONE, BUSY}), 64'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end
endmodule
